// File: rtl/itrx_aib_phy_redn_ctrl.sv
// itrx_aib_phy_redn_ctrl
// Sequences a redundancy-mux update for a row of AIB IO cells. A repair
// request is accepted only while idle; the IO is then held quiet, the new
// engage vector is loaded in one SWITCH cycle, the muxes are given time to
// settle, and the IO is released with a one-cycle done pulse.
//
// Engage vector: bit i is set when i >= the latched failing index, so every
// cell from the failing one upward shifts onto its neighbour. An index
// >= NCELL disengages all cells.
//
// Optional feature, selected with the macro ITRX_AIB_PHY_REDN_CTRL_LOCK_EN:
// once a sequence finishes with a nonzero engage vector, the repair is locked.
// Later requests are refused with a one-cycle err pulse. Only reset clears
// the lock. In the default build there is no lock and err_o is tied low.
//
// Handshake: req_i is a level that is sampled only in IDLE. Acceptance is
// confirmed by a one-cycle ack_o pulse in the first QUIESCE cycle. The end of
// the sequence is marked by a one-cycle done_o pulse in the RELEASE cycle.
// While busy_o is high, req_i and fail_idx_i are ignored.
//
// dbg_state_o exposes the FSM state: 0 IDLE, 1 QUIESCE, 2 SWITCH,
// 3 SETTLE, 4 RELEASE.

module itrx_aib_phy_redn_ctrl #(
   parameter int NCELL       = 24,
   parameter int IDXW        = 5,
   parameter int QUIESCE_CYC = 8,
   parameter int SETTLE_CYC  = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_i,
   input  logic [IDXW-1:0]   fail_idx_i,
   output logic              ack_o,
   output logic              done_o,
   output logic              busy_o,
   output logic              io_quiesce_o,
   output logic [NCELL-1:0]  redn_engage_o,
   output logic              err_o,
   output logic [2:0]        dbg_state_o
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_QUIESCE = 3'd1,
      ST_SWITCH  = 3'd2,
      ST_SETTLE  = 3'd3,
      ST_RELEASE = 3'd4
   } state_e;

   // Counter reload values. A phase of N cycles counts N-1 down to 0.
   localparam logic [7:0]      QUIESCE_LOAD = 8'(QUIESCE_CYC - 1);
   localparam logic [7:0]      SETTLE_LOAD  = 8'(SETTLE_CYC - 1);
   localparam logic [IDXW-1:0] IDX_LIMIT    = IDXW'(NCELL);

   state_e            state_q;
   logic [7:0]        cnt_q;
   logic [IDXW-1:0]   idx_q;
   logic [NCELL-1:0]  engage_q;
   logic [NCELL-1:0]  engage_d;
   logic              quiesce_q;
   logic              ack_q;
   logic              done_q;
   logic              busy_q;
   logic              accept;

`ifdef ITRX_AIB_PHY_REDN_CTRL_LOCK_EN
   logic              lock_q;
   logic              err_q;

   assign accept = req_i && !lock_q;
   assign err_o  = err_q;
`else
   assign accept = req_i;
   assign err_o  = 1'b0;
`endif

   // Build the engage vector from the latched index.
   always_comb begin
      engage_d = '0;
      for (int i = 0; i < NCELL; i++) begin
         engage_d[i] = (idx_q < IDX_LIMIT) && (IDXW'(i) >= idx_q);
      end
   end

   // Repair sequencer. All outputs are registered here.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         engage_q  <= '0;
         quiesce_q <= 1'b0;
         ack_q     <= 1'b0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
`ifdef ITRX_AIB_PHY_REDN_CTRL_LOCK_EN
         lock_q    <= 1'b0;
         err_q     <= 1'b0;
`endif
      end else begin
         ack_q  <= 1'b0;
         done_q <= 1'b0;
`ifdef ITRX_AIB_PHY_REDN_CTRL_LOCK_EN
         err_q  <= 1'b0;
`endif
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  state_q   <= ST_QUIESCE;
                  idx_q     <= fail_idx_i;
                  cnt_q     <= QUIESCE_LOAD;
                  ack_q     <= 1'b1;
                  quiesce_q <= 1'b1;
                  busy_q    <= 1'b1;
               end
`ifdef ITRX_AIB_PHY_REDN_CTRL_LOCK_EN
               if (req_i && lock_q) begin
                  err_q <= 1'b1;
               end
`endif
            end
            ST_QUIESCE: begin
               if (cnt_q == 8'd0) begin
                  state_q <= ST_SWITCH;
               end else begin
                  cnt_q <= cnt_q - 8'd1;
               end
            end
            ST_SWITCH: begin
               // The only edge where the mux selection is allowed to move.
               engage_q <= engage_d;
               cnt_q    <= SETTLE_LOAD;
               state_q  <= ST_SETTLE;
            end
            ST_SETTLE: begin
               if (cnt_q == 8'd0) begin
                  state_q   <= ST_RELEASE;
                  quiesce_q <= 1'b0;
                  done_q    <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 8'd1;
               end
            end
            ST_RELEASE: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
`ifdef ITRX_AIB_PHY_REDN_CTRL_LOCK_EN
               lock_q  <= lock_q | (|engage_q);
`endif
            end
            default: begin
               state_q   <= ST_IDLE;
               quiesce_q <= 1'b0;
               busy_q    <= 1'b0;
            end
         endcase
      end
   end

   assign ack_o         = ack_q;
   assign done_o        = done_q;
   assign busy_o        = busy_q;
   assign io_quiesce_o  = quiesce_q;
   assign redn_engage_o = engage_q;
   assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_itrx_aib_phy_redn_ctrl.sv
// Bench for itrx_aib_phy_redn_ctrl: directed vectors with hand-computed
// expectations on a default-parameter instance and on a
// QUIESCE_CYC=1 / SETTLE_CYC=1 instance.
module tb_itrx_aib_phy_redn_ctrl;

   localparam int NCELL = 24;
   localparam int IDXW  = 5;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst, req, ack, done, busy, ioq, err;
   logic [IDXW-1:0]  fidx;
   logic [NCELL-1:0] eng;
   logic [2:0]       st;

   logic             rst2, req2, ack2, done2, busy2, ioq2, err2;
   logic [IDXW-1:0]  fidx2;
   logic [NCELL-1:0] eng2;
   logic [2:0]       st2;

   itrx_aib_phy_redn_ctrl #(.NCELL(NCELL), .IDXW(IDXW), .QUIESCE_CYC(8), .SETTLE_CYC(16)) dut (
      .clk_i(clk), .rst_i(rst), .req_i(req), .fail_idx_i(fidx),
      .ack_o(ack), .done_o(done), .busy_o(busy), .io_quiesce_o(ioq),
      .redn_engage_o(eng), .err_o(err), .dbg_state_o(st)
   );

   itrx_aib_phy_redn_ctrl #(.NCELL(NCELL), .IDXW(IDXW), .QUIESCE_CYC(1), .SETTLE_CYC(1)) dut2 (
      .clk_i(clk), .rst_i(rst2), .req_i(req2), .fail_idx_i(fidx2),
      .ack_o(ack2), .done_o(done2), .busy_o(busy2), .io_quiesce_o(ioq2),
      .redn_engage_o(eng2), .err_o(err2), .dbg_state_o(st2)
   );

   // ---------------- scoreboard counters ----------------
   int n_cmp = 0;
   int n_mis = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   // Present a request for one edge and check it is acknowledged.
   task automatic start(input string tag, input logic [IDXW-1:0] idx, input bit keep);
      req  = 1'b1;
      fidx = idx;
      tick();
      chk({tag, " ack"}, 64'(ack), 64'd1);
      chk({tag, " ioq"}, 64'(ioq), 64'd1);
      if (!keep) req = 1'b0;
   endtask

   // Sequence monitor; index 0 is the ack cycle.
   int               o_nq, o_chg, o_done, o_ndone, o_nack, o_ack_at, o_nerr, o_bad, o_idle;
   logic [NCELL-1:0] o_chg_val;

   task automatic observe(input int inj_at, input logic [IDXW-1:0] inj_idx, input bit hold);
      logic [NCELL-1:0] prev;
      prev      = eng;
      o_nq      = ioq ? 1 : 0;
      o_chg     = -1;
      o_done    = -1;
      o_ndone   = 0;
      o_nack    = 0;
      o_ack_at  = -1;
      o_nerr    = 0;
      o_bad     = 0;
      o_idle    = 0;
      o_chg_val = '0;
      for (int k = 1; k <= 80; k++) begin
         if (k == inj_at) begin
            req  = 1'b1;
            fidx = inj_idx;
         end else if (k == inj_at + 1 && !hold) begin
            req = 1'b0;
         end
         tick();
         if (o_done < 0 && ioq) o_nq++;
         if (eng !== prev) begin
            if (o_chg < 0) begin
               o_chg     = k;
               o_chg_val = eng;
            end
            if (!ioq) o_bad++;
         end
         prev = eng;
         if (done) begin
            o_ndone++;
            if (o_done < 0) o_done = k;
         end
         if (ack) begin
            o_nack++;
            if (o_ack_at < 0) o_ack_at = k;
         end
         if (err) o_nerr++;
         if (o_done >= 0 && k == o_done + 1) o_idle = busy ? 0 : 1;
         if (o_done >= 0 && k == o_done + 2) break;
      end
   endtask

   task automatic check_seq(input string tag, input int exp_chg, input logic [NCELL-1:0] exp_val);
      chk({tag, " quiesce_len"}, 64'(o_nq), 64'd25);
      chk({tag, " done_at"}, 64'(o_done), 64'd25);
      chk({tag, " done_cnt"}, 64'(o_ndone), 64'd1);
      chk({tag, " chg_at"}, 64'(o_chg), 64'(exp_chg));
      chk({tag, " engage"}, 64'(eng), 64'(exp_val));
      chk({tag, " chg_unquiet"}, 64'(o_bad), 64'd0);
      chk({tag, " idle_after"}, 64'(o_idle), 64'd1);
      chk({tag, " extra_ack"}, 64'(o_nack), 64'd0);
      chk({tag, " err_cnt"}, 64'(o_nerr), 64'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int cnt;
      int chg2, done2_at, bad2;
      logic [NCELL-1:0] prev2;
      rst   = 1'b1;
      req   = 1'b0;
      fidx  = '0;
      rst2  = 1'b1;
      req2  = 1'b0;
      fidx2 = '0;
      tick();
      tick();

      // Reset state
      chk("rst ack", 64'(ack), 64'd0);
      chk("rst done", 64'(done), 64'd0);
      chk("rst busy", 64'(busy), 64'd0);
      chk("rst ioq", 64'(ioq), 64'd0);
      chk("rst engage", 64'(eng), 64'd0);
      chk("rst err", 64'(err), 64'd0);
      chk("rst state", 64'(st), 64'd0);
      rst = 1'b0;
      tick();
      chk("idle noreq busy", 64'(busy), 64'd0);

      // Engage from index 5; a request during SETTLE must be ignored.
      start("seq5", 5'd5, 1'b0);
      observe(12, 5'd2, 1'b0);
      check_seq("seq5", 9, 24'hFFFFE0);
      chk("seq5 chg_val", 64'(o_chg_val), 64'hFFFFE0);

`ifndef ITRX_AIB_PHY_REDN_CTRL_LOCK_EN
      // Disengage-all after a prior engage.
      start("seq31", 5'd31, 1'b0);
      observe(0, 5'd0, 1'b0);
      check_seq("seq31", 9, 24'h000000);
`else
      // Locked: a later request is refused.
      req  = 1'b1;
      fidx = 5'd31;
      tick();
      req = 1'b0;
      chk("lock31 ack", 64'(ack), 64'd0);
      chk("lock31 err", 64'(err), 64'd1);
      tick();
      chk("lock31 err_len", 64'(err), 64'd0);
      chk("lock31 engage", 64'(eng), 64'hFFFFE0);
      chk("lock31 busy", 64'(busy), 64'd0);
`endif

      // Index == NCELL, then reload of the same all-zero vector.
      do_reset();
      start("seq24", 5'd24, 1'b0);
      observe(0, 5'd0, 1'b0);
      check_seq("seq24", -1, 24'h000000);
      start("reload", 5'd31, 1'b0);
      observe(0, 5'd0, 1'b0);
      check_seq("reload", -1, 24'h000000);

      // Reset during QUIESCE cycle 3.
      do_reset();
      start("abortq", 5'd5, 1'b0);
      tick();
      tick();
      chk("abortq in_quiesce", 64'(ioq), 64'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abortq busy", 64'(busy), 64'd0);
      chk("abortq ioq", 64'(ioq), 64'd0);
      chk("abortq engage", 64'(eng), 64'd0);
      cnt = 0;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (done) cnt++;
      end
      chk("abortq no_done", 64'(cnt), 64'd0);

      // Reset during SWITCH.
      do_reset();
      start("aborts", 5'd3, 1'b0);
      for (int k = 0; k < 8; k++) tick();
      chk("aborts in_switch", 64'(st), 64'd2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("aborts engage", 64'(eng), 64'd0);
      chk("aborts busy", 64'(busy), 64'd0);
      cnt = 0;
      for (int k = 0; k < 30; k++) begin
         tick();
         if (done) cnt++;
         if (eng !== '0) cnt++;
      end
      chk("aborts quiet_after", 64'(cnt), 64'd0);

      // Engage index 0, then request index 7.
      do_reset();
      start("seq0", 5'd0, 1'b0);
      observe(0, 5'd0, 1'b0);
      check_seq("seq0", 9, 24'hFFFFFF);
      req  = 1'b1;
      fidx = 5'd7;
      tick();
      req = 1'b0;
`ifdef ITRX_AIB_PHY_REDN_CTRL_LOCK_EN
      chk("lock7 ack", 64'(ack), 64'd0);
      chk("lock7 err", 64'(err), 64'd1);
      tick();
      chk("lock7 err_len", 64'(err), 64'd0);
      chk("lock7 engage", 64'(eng), 64'hFFFFFF);
`else
      chk("seq7 ack", 64'(ack), 64'd1);
      chk("seq7 err", 64'(err), 64'd0);
      observe(0, 5'd0, 1'b0);
      check_seq("seq7", 9, 24'hFFFF80);
`endif

      // Held request is re-accepted only after the first IDLE cycle.
      do_reset();
      start("hold", 5'd31, 1'b1);
      observe(0, 5'd0, 1'b1);
      chk("hold done_at", 64'(o_done), 64'd25);
      chk("hold idle_after", 64'(o_idle), 64'd1);
      chk("hold reack_at", 64'(o_ack_at), 64'd27);
      chk("hold ack_cnt", 64'(o_nack), 64'd1);
      req = 1'b0;
      observe(0, 5'd0, 1'b0);
      check_seq("hold2", -1, 24'h000000);

      // Minimum phase lengths on the second instance, top-cell index.
      rst2 = 1'b1;
      tick();
      rst2 = 1'b0;
      chk("min rst engage", 64'(eng2), 64'd0);
      req2  = 1'b1;
      fidx2 = 5'd23;
      tick();
      req2 = 1'b0;
      chk("min ack", 64'(ack2), 64'd1);
      prev2    = eng2;
      chg2     = -1;
      done2_at = -1;
      bad2     = 0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (eng2 !== prev2) begin
            if (chg2 < 0) chg2 = k;
            if (!ioq2) bad2++;
         end
         prev2 = eng2;
         if (done2 && done2_at < 0) done2_at = k;
         if (done2_at >= 0 && k == done2_at + 1) break;
      end
      chk("min chg_at", 64'(chg2), 64'd2);
      chk("min done_at", 64'(done2_at), 64'd3);
      chk("min engage", 64'(eng2), 64'h800000);
      chk("min chg_unquiet", 64'(bad2), 64'd0);
      chk("min busy_after", 64'(busy2), 64'd0);
      chk("min err", 64'(err2), 64'd0);

      // ---------------- report ----------------
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
